// File: rtl/output_display_driver.sv
// Captures an 8-bit value, converts it to BCD by sequential double-dabble (8 cycles, load ignored while busy)
// and drives a 3-digit multiplexed 7-segment display with leading-zero blanking; no backpressure.
module output_display_driver #(
  parameter int REFRESH_DIV  = 1024,
  parameter bit COMMON_ANODE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [7:0]  dataIn,
  output logic        busy,
  output logic        valid,
  output logic [11:0] bcdOut,
  output logic [6:0]  segments,
  output logic [2:0]  digitSelect
);

  typedef enum logic [1:0] {IDLE, CONVERT, DISPLAY} state_t;

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REF_MAX = CW'(REFRESH_DIV - 1);

  state_t        state;
  logic [7:0]    shiftReg;
  logic [11:0]   scratch;
  logic [2:0]    iterCnt;
  logic [CW-1:0] refCnt;
  logic [2:0]    selReg;

  logic [11:0]   adjusted;
  logic [19:0]   shifted;

  function automatic logic [3:0] addThree(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] decodeDigit(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // One double-dabble step: adjust every nibble first, then shift the whole window left.
  always_comb begin
    adjusted = {addThree(scratch[11:8]), addThree(scratch[7:4]), addThree(scratch[3:0])};
    shifted  = {adjusted, shiftReg} << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      valid    <= 1'b0;
      bcdOut   <= 12'h000;
      iterCnt  <= 3'd0;
      shiftReg <= 8'h00;
      scratch  <= 12'h000;
    end else begin
      case (state)
        IDLE, DISPLAY: begin
          if (load) begin
            shiftReg <= dataIn;
            scratch  <= 12'h000;
            iterCnt  <= 3'd0;
            busy     <= 1'b1;
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          scratch  <= shifted[19:8];
          shiftReg <= shifted[7:0];
          iterCnt  <= iterCnt + 3'd1;
          if (iterCnt == 3'd7) begin
            bcdOut <= shifted[19:8];
            valid  <= 1'b1;
            busy   <= 1'b0;
            state  <= DISPLAY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refCnt <= '0;
      selReg <= 3'b001;
    end else if (refCnt == REF_MAX) begin
      refCnt <= '0;
      selReg <= {selReg[1:0], selReg[2]};
    end else begin
      refCnt <= refCnt + 1'b1;
    end
  end

  logic [3:0] curDigit;
  logic       curBlank;
  logic [6:0] segRaw;

  always_comb begin
    curDigit = bcdOut[3:0];
    curBlank = 1'b0;
    case (selReg)
      3'b010: begin
        curDigit = bcdOut[7:4];
        curBlank = (bcdOut[11:8] == 4'd0) && (bcdOut[7:4] == 4'd0);
      end
      3'b100: begin
        curDigit = bcdOut[11:8];
        curBlank = (bcdOut[11:8] == 4'd0);
      end
      default: begin
        curDigit = bcdOut[3:0];
        curBlank = 1'b0;
      end
    endcase
    segRaw = (!valid || curBlank) ? 7'h00 : decodeDigit(curDigit);
  end

  assign segments    = COMMON_ANODE ? ~segRaw : segRaw;
  assign digitSelect = COMMON_ANODE ? ~selReg : selReg;

endmodule

// File: tb/tb_output_display_driver.sv
// Directed bench: one common-cathode instance (REFRESH_DIV=4) and one common-anode instance
// (REFRESH_DIV=1) share clock and stimulus.
module tb_output_display_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [7:0]  dataIn;
  logic        busy, valid;
  logic [11:0] bcdOut;
  logic [6:0]  segments;
  logic [2:0]  digitSelect;
  logic        caBusy, caValid;
  logic [11:0] caBcdOut;
  logic [6:0]  caSegments;
  logic [2:0]  caDigitSelect;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  output_display_driver #(.REFRESH_DIV(4), .COMMON_ANODE(1'b0)) dut (
    .clk(clk), .rst(rst), .load(load), .dataIn(dataIn),
    .busy(busy), .valid(valid), .bcdOut(bcdOut),
    .segments(segments), .digitSelect(digitSelect)
  );

  output_display_driver #(.REFRESH_DIV(1), .COMMON_ANODE(1'b1)) dutCa (
    .clk(clk), .rst(rst), .load(load), .dataIn(dataIn),
    .busy(caBusy), .valid(caValid), .bcdOut(caBcdOut),
    .segments(caSegments), .digitSelect(caDigitSelect)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadValue(input logic [7:0] v);
    dataIn = v;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  // Aligns to a digitSelect rotation, then walks all three slots checking hold time and segments.
  task automatic checkMux(input string tag, input logic [6:0] hund, input logic [6:0] tens,
                          input logic [6:0] ones);
    logic [2:0] prev, cur;
    logic [6:0] exp;
    bit changed;
    prev = digitSelect;
    changed = 1'b0;
    for (int i = 0; i < 8 && !changed; i++) begin
      tick();
      changed = (digitSelect != prev);
    end
    check({tag, " sync"}, 16'(changed), 16'd1);
    for (int s = 0; s < 3; s++) begin
      cur = digitSelect;
      case (cur)
        3'b001:  exp = ones;
        3'b010:  exp = tens;
        3'b100:  exp = hund;
        default: exp = 7'h7F;
      endcase
      check({tag, " onehot"}, 16'(cur == 3'b001 || cur == 3'b010 || cur == 3'b100), 16'd1);
      check({tag, " seg"}, 16'(segments), 16'(exp));
      repeat (3) begin
        tick();
        check({tag, " hold"}, 16'(digitSelect), 16'(cur));
      end
      tick();
      check({tag, " rotate"}, 16'(digitSelect), 16'({cur[1:0], cur[2]}));
    end
  endtask

  initial begin
    logic [2:0] caSel;
    rst = 1'b1; load = 1'b1; dataIn = 8'hFF;
    tick(); tick();
    check("rst busy",   16'(busy),        16'd0);
    check("rst valid",  16'(valid),       16'd0);
    check("rst bcd",    16'(bcdOut),      16'h000);
    check("rst seg",    16'(segments),    16'h00);
    check("rst sel",    16'(digitSelect), 16'b001);
    check("rst caSeg",  16'(caSegments),  16'h7F);
    check("rst caSel",  16'(caDigitSelect), 16'b110);
    rst = 1'b0; load = 1'b0;
    tick(); tick();
    check("idle busy", 16'(busy), 16'd0);

    // 255: busy for exactly 8 cycles, bcdOut stays old until completion
    loadValue(8'd255);
    for (int i = 0; i < 8; i++) begin
      check("c255 busy", 16'(busy), 16'd1);
      check("c255 hold", 16'(bcdOut), 16'h000);
      tick();
    end
    check("c255 busyOff", 16'(busy),   16'd0);
    check("c255 bcd",     16'(bcdOut), 16'h255);
    check("c255 valid",   16'(valid),  16'd1);
    checkMux("m255", 7'h5B, 7'h6D, 7'h6D);

    loadValue(8'd7);
    repeat (9) tick();
    check("c7 bcd", 16'(bcdOut), 16'h007);
    checkMux("m7", 7'h00, 7'h00, 7'h07);

    loadValue(8'd105);
    repeat (9) tick();
    check("c105 bcd", 16'(bcdOut), 16'h105);
    checkMux("m105", 7'h06, 7'h3F, 7'h6D);

    loadValue(8'd10);
    repeat (9) tick();
    check("c10 bcd", 16'(bcdOut), 16'h010);
    checkMux("m10", 7'h00, 7'h06, 7'h3F);

    loadValue(8'd0);
    repeat (9) tick();
    check("c0 bcd",   16'(bcdOut), 16'h000);
    check("c0 valid", 16'(valid),  16'd1);
    checkMux("m0", 7'h00, 7'h00, 7'h3F);
    check("ca0 bcd", 16'(caBcdOut), 16'h000);
    for (int i = 0; i < 6; i++) begin
      caSel = caDigitSelect;
      check("ca0 seg", 16'(caSegments), (caSel == 3'b110) ? 16'h40 : 16'h7F);
      tick();
      check("ca0 rotate", 16'(caDigitSelect), 16'({caSel[1:0], caSel[2]}));
    end

    // load during conversion is dropped
    loadValue(8'd200);
    tick(); tick();
    dataIn = 8'd50; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (4) begin
      check("ign busy", 16'(busy), 16'd1);
      tick();
    end
    check("ign lastBusy", 16'(busy), 16'd1);
    tick();
    check("ign busyOff", 16'(busy),   16'd0);
    check("ign bcd",     16'(bcdOut), 16'h200);
    tick();
    check("ign noRestart", 16'(busy), 16'd0);
    check("ca200 bcd", 16'(caBcdOut), 16'h200);

    // reset mid-conversion
    loadValue(8'd99);
    tick(); tick(); tick();
    check("mid busy", 16'(busy), 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid busy0",  16'(busy),     16'd0);
    check("mid valid0", 16'(valid),    16'd0);
    check("mid bcd0",   16'(bcdOut),   16'h000);
    check("mid seg0",   16'(segments), 16'h00);
    check("mid sel",    16'(digitSelect), 16'b001);
    repeat (10) tick();
    check("mid stayIdle", 16'(busy), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
